data_store_rx_buffer: RTL and testbench
=======================================

// Module: data_store_rx_buffer
// PURPOSE
// Receive-side frame store between the Ethernet RX path and the consumer.
// - Packs N-bit beats (MSB-first) into 16-bit words.
// - Strips the trailing 32-bit FCS of each frame.
// - Buffers words in a RAM FIFO; replays them in order when read_request is asserted.
// PARAMETERS
// N      2     input beat width in bits; 16 % N == 0 and 32 % N == 0 (legal: 1,2,4,8,16)
// DEPTH  1024  buffer capacity in 16-bit words (power of two)
// PORTS
// clk           in   1   single system clock
// rst           in   1   synchronous, active-low reset
// axiid         in   N   RX beat data, first beat = most-significant bits of a word
// axiiv         in   1   RX beat valid; high for a whole frame, low between frames
// read_request  in   1   level; while high, stored words are streamed out
// axiod         out  16  output word
// axiov         out  1   output word valid
// BEHAVIOUR
// Reset (rst==0 at posedge):
// - axiov=0, axiod=0.
// - Read/write pointers, fill count, beat counter, FCS delay line and valid pipeline all cleared.
// - Stored data is discarded; reset wins over any simultaneous event.
// Ingress:
// - Each axiiv beat enters a delay line of D = 32/N beats.
// - A beat is committed to the packer only when pushed out of the delay line by a newer valid beat.
// - When axiiv falls, the D beats still in the line (the FCS) are dropped and the line is emptied.
// - Packer shifts committed beats in MSB-first; after 16/N beats the word is written to RAM at wr_ptr.
// - A partial word at end of frame is discarded; the beat counter clears when axiiv falls.
// - Frames shorter than or equal to 32 bits store nothing.
// - Consecutive frames append to the FIFO in arrival order.
// Overflow:
// - A word completed while count==DEPTH is dropped; stored contents are unaffected.
// Egress:
// - Each cycle read_request==1 and count>0 (count includes the word written this cycle), one RAM read is issued and rd_ptr increments.
// - The word appears on axiod with axiov=1 exactly 2 cycles after the read is issued: 1 cycle registered RAM read, 1 cycle output register.
// - Sustained throughput is 1 word/clk.
// - read_request low, or FIFO empty: no read issued. In-flight reads (up to 2) still complete.
// - axiov=0 on every cycle without a completing read; axiod holds its last value.
// Pointers and simultaneous access:
// - Pointers wrap modulo DEPTH.
// - Write and read in the same cycle leave count unchanged.
// - Empty: count==0. Full: count==DEPTH.
// STRUCTURE
// Shared package rx_pkg:
// - localparam WORD_W = 16, FCS_BITS = 32.
// - Function beats_per_word(N) = WORD_W/N.
// Sub-module rx_word_ram:
// - Simple dual-port RAM, DEPTH x 16.
// - One write port, one registered read port, 1-cycle read latency.
// Remaining logic in the top level:
// - FCS delay line, packer, pointers/count, valid pipeline.
// TESTING (bench uses N=4, 40 ns clock)
// 1. Reset with rst low 1 cycle -> axiov=0, axiod=0; read_request=1 on empty FIFO keeps axiov=0.
// 2. One frame of nibbles (1,E,4,B,8,1,8,0)x3, then words 0..199 as 4 nibbles each (800 beats), then 8 more beats of 7 (FCS), then axiiv=0 -> nothing output while read_request=0.
// 3. Raise read_request and hold -> 2 cycles later axiov=1 with axiod = 1E4B, 8180, 1E4B, 8180, 1E4B, 8180, then 0000..00C7 on consecutive cycles; following cycles axiov=0 (FCS words 7777 never appear).
// 4. Frame of 3 nibbles A,B,C + 8 FCS beats -> no word stored; read yields axiov=0.
// 5. Toggle read_request 1-0-1 mid-stream -> no duplicated or skipped words; up to 2 words still arrive after the drop.
// 6. Write DEPTH+4 words without reading -> exactly DEPTH words read back, the first DEPTH written; then axiov=0.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared widths and helpers for the RX frame store.
// Latency: none (package); backpressure: n/a.
`timescale 1ns/1ps
package rx_pkg;
  localparam int WORD_W   = 16;
  localparam int FCS_BITS = 32;

  function automatic int beats_per_word(input int n);
    return WORD_W / n;
  endfunction
endpackage

// File: rtl/rx_word_ram.sv
// DEPTH x WORD_W simple dual-port RAM, write-first on same-address collisions.
// Latency: 1 cycle registered read; backpressure: none, every request is served.
`timescale 1ns/1ps
module rx_word_ram
  import rx_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];

  // Bypass lets a word written this cycle be read back in the same cycle (empty FIFO case).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end
endmodule

// File: rtl/data_store_rx_buffer.sv
// RX frame store: strips FCS, packs N-bit beats MSB-first into words, FIFOs them out on read_request.
// Latency: 2 cycles from read issue to axiov; backpressure: none, words completed while full are dropped.
`timescale 1ns/1ps
module data_store_rx_buffer
  import rx_pkg::*;
#(
  parameter int N     = 2,
  parameter int DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      axiid,
  input  logic              axiiv,
  input  logic              read_request,
  output logic [WORD_W-1:0] axiod,
  output logic              axiov
);
  localparam int D   = FCS_BITS / N;
  localparam int BPW = beats_per_word(N);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DCW = $clog2(D + 1);
  localparam int BCW = $clog2(BPW + 1);

  logic [D-1:0][N-1:0] dline;
  logic [DCW-1:0]      dl_fill;
  logic [WORD_W-1:0]   pack;
  logic [BCW-1:0]      beat_cnt;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                rd_vld;
  logic [WORD_W-1:0]   ram_q;

  logic                commit, word_done, wr_en, rd_en, full;
  logic [N-1:0]        beat;
  logic [WORD_W-1:0]   word;

  // A beat only leaves the delay line once D newer beats exist, so the last D beats (FCS) never commit.
  assign commit    = axiiv && (dl_fill == DCW'(D));
  assign beat      = dline[D-1];
  assign word      = WORD_W'({pack, beat});
  assign word_done = commit && (beat_cnt == BCW'(BPW - 1));
  assign full      = (count == CW'(DEPTH));
  assign wr_en     = word_done && !full;
  assign rd_en     = read_request && ((count != '0) || wr_en);

  always_ff @(posedge clk) begin
    if (!rst) begin
      dline    <= '0;
      dl_fill  <= '0;
      pack     <= '0;
      beat_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_vld   <= 1'b0;
      axiov    <= 1'b0;
      axiod    <= '0;
    end else begin
      if (axiiv) begin
        dline <= {dline[D-2:0], axiid};
        if (!commit) dl_fill <= dl_fill + DCW'(1);
      end else begin
        dline    <= '0;
        dl_fill  <= '0;
        beat_cnt <= '0;
      end
      if (commit) begin
        pack     <= word;
        beat_cnt <= word_done ? '0 : beat_cnt + BCW'(1);
      end
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count  <= count + CW'(wr_en) - CW'(rd_en);
      rd_vld <= rd_en;
      axiov  <= rd_vld;
      if (rd_vld) axiod <= ram_q;
    end
  end

  rx_word_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (word),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );
endmodule

// File: tb/tb_data_store_rx_buffer.sv
// Directed bench for data_store_rx_buffer with a scoreboard of expected output words.
`timescale 1ns/1ps
module tb_data_store_rx_buffer;
  localparam int N     = 4;
  localparam int DEPTH = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] axiid;
  logic         axiiv;
  logic         read_request;
  logic [15:0]  axiod;
  logic         axiov;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  logic [3:0]  frm[$];

  always #20 clk = ~clk;

  data_store_rx_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .axiid        (axiid),
    .axiiv        (axiiv),
    .read_request (read_request),
    .axiod        (axiod),
    .axiov        (axiov)
  );

  initial begin
    #5_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int ones;
    logic [15:0] w;

    rst = 1'b0; axiiv = 1'b0; axiid = '0; read_request = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // 1. reset state, reading an empty FIFO
    check("reset_axiov", 16'(axiov), 16'h0);
    check("reset_axiod", axiod, 16'h0);
    read_request = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("empty_read_axiov", 16'(axiov), 16'h0);
    end
    read_request = 1'b0;

    // output monitor: every valid word must match the head of the scoreboard
    fork
      forever begin
        @(negedge clk);
        if (axiov === 1'b1) begin
          n_cmp++;
          assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_word got=%h exp=none", axiod);
          end
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            assert (axiod === w) else begin
              n_fail++;
              $error("FAIL out_word got=%h exp=%h", axiod, w);
            end
          end
        end
      end
    join_none

    // 2. header pattern x3, words 0..199, FCS of 7s; nothing comes out without read_request
    frm.delete();
    for (int r = 0; r < 3; r++) begin
      add_word(16'h1E4B);
      add_word(16'h8180);
    end
    for (int i = 0; i < 200; i++) add_word(16'(i));
    for (int i = 0; i < 8; i++) frm.push_back(4'h7);
    send_frame();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_no_read_axiov", 16'(axiov), 16'h0);
    end

    // 3. read latency of 2 cycles, then one word per clock
    read_request = 1'b1;
    @(negedge clk);
    check("lat_cycle1_axiov", 16'(axiov), 16'h0);
    @(negedge clk);
    check("lat_cycle2_axiov", 16'(axiov), 16'h1);
    for (int i = 0; i < 205; i++) begin
      @(negedge clk);
      check("stream_axiov", 16'(axiov), 16'h1);
    end
    drain(20);

    // 4. a frame no longer than the FCS plus a partial word stores nothing
    frm.delete();
    frm.push_back(4'hA); frm.push_back(4'hB); frm.push_back(4'hC);
    for (int i = 0; i < 8; i++) frm.push_back(4'h7);
    send_frame();
    read_request = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("short_frame_axiov", 16'(axiov), 16'h0);
      check("axiod_hold", axiod, 16'h00C7);
    end
    read_request = 1'b0;

    // 5. pause reading mid-stream
    frm.delete();
    for (int i = 0; i < 20; i++) add_word(16'hA500 + 16'(i * 3));
    for (int i = 0; i < 8; i++) frm.push_back(4'hF);
    send_frame();
    read_request = 1'b1;
    repeat (6) @(negedge clk);
    ones = int'(axiov);
    read_request = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ones += int'(axiov);
    end
    check("words_after_drop", 16'(ones), 16'd2);
    drain(40);

    // 6. overflow: only the first DEPTH words survive
    frm.delete();
    for (int i = 0; i < DEPTH + 4; i++) add_word(16'(i * 40503 + 7));
    for (int i = 0; i < 8; i++) frm.push_back(4'h3);
    send_frame();
    drain(DEPTH + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic add_word(input logic [15:0] w);
    frm.push_back(w[15:12]);
    frm.push_back(w[11:8]);
    frm.push_back(w[7:4]);
    frm.push_back(w[3:0]);
  endtask

  // Model: beats past the trailing 8 are FCS, partial words are lost, overflow drops new words.
  task automatic send_frame();
    int nd;
    logic [15:0] w;
    nd = frm.size() - 8;
    for (int k = 0; k + 4 <= nd; k += 4) begin
      w = {frm[k], frm[k+1], frm[k+2], frm[k+3]};
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
    end
    for (int k = 0; k < frm.size(); k++) begin
      axiiv = 1'b1;
      axiid = frm[k];
      @(negedge clk);
    end
    axiiv = 1'b0;
    axiid = '0;
    @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int cyc;
    cyc = 0;
    read_request = 1'b1;
    while (exp_q.size() != 0 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain_timeout left=%0d exp=0", exp_q.size());
    end
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("after_drain_axiov", 16'(axiov), 16'h0);
    end
    read_request = 1'b0;
  endtask
endmodule
